// File: rtl/magnitude_aggregator.sv
// magnitude_aggregator: latches per-channel magnitude strobes into aligned snapshots
// and streams each one as a sequenced AXI-Stream frame (header word + NUM_CH data words).
module magnitude_aggregator #(
  parameter int NUM_CH     = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         enable,
  input  logic [NUM_CH-1:0]            ch_mask,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_CH-1:0]            s_tvalid,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tuser,
  output logic [15:0]                  overrun_cnt,
  output logic [15:0]                  timeout_cnt
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_CH-1:0]     pending_q, pending_d;
  logic [DATA_WIDTH-1:0] hold_q  [NUM_CH];
  logic [DATA_WIDTH-1:0] hold_d  [NUM_CH];
  logic [DATA_WIDTH-1:0] frame_q [NUM_CH];
  logic [DATA_WIDTH-1:0] frame_d [NUM_CH];
  logic [NUM_CH-1:0]     vmask_q, vmask_d;
  logic [15:0]           seq_q, seq_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [15:0]           overrun_q, overrun_d;
  logic [15:0]           tmo_cnt_q, tmo_cnt_d;

  logic [NUM_CH-1:0]     strobe;
  logic                  complete;
  logic                  timer_hit;
  logic                  snap;
  logic                  handshake;
  logic                  overrun_any;
  logic [15:0]           hdr_mask;

  // Outputs come straight from registered state, so they hold steady under stall.
  always_comb begin
    hdr_mask      = 16'(vmask_q);
    m_axis_tvalid = (state_q != IDLE);
    m_axis_tuser  = (state_q == HDR);
    m_axis_tlast  = (state_q == DATA) && (idx_q == LAST_IDX);
    m_axis_tdata  = '0;
    case (state_q)
      HDR:     m_axis_tdata = DATA_WIDTH'({seq_q, hdr_mask});
      DATA:    m_axis_tdata = frame_q[idx_q];
      default: m_axis_tdata = '0;
    endcase
  end

  always_comb begin
    strobe      = enable ? s_tvalid : '0;
    complete    = (ch_mask != '0) && ((pending_q & ch_mask) == ch_mask);
    timer_hit   = (pending_q != '0) && (timer_q == TMR_LAST);
    snap        = (state_q == IDLE) && (complete || timer_hit);
    handshake   = m_axis_tvalid && m_axis_tready;
    overrun_any = ((pending_q & strobe) != '0) && !snap;

    state_d   = state_q;
    pending_d = pending_q;
    hold_d    = hold_q;
    frame_d   = frame_q;
    vmask_d   = vmask_q;
    seq_d     = seq_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    tmo_cnt_d = tmo_cnt_q;

    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (strobe[i]) begin
        hold_d[i] = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    // A strobe landing in the snapshot cycle stays pending for the next frame.
    pending_d = snap ? strobe : (pending_q | strobe);

    if (overrun_any && (overrun_q != 16'hFFFF)) begin
      overrun_d = overrun_q + 16'd1;
    end

    if (snap || (pending_q == '0)) begin
      timer_d = '0;
    end else if (state_q == IDLE) begin
      timer_d = timer_q + TMR_W'(1);
    end

    if (snap) begin
      vmask_d = pending_q;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        frame_d[i] = pending_q[i] ? hold_q[i] : '0;
      end
      if (timer_hit && !complete && (tmo_cnt_q != 16'hFFFF)) begin
        tmo_cnt_d = tmo_cnt_q + 16'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (snap) begin
          state_d = HDR;
        end
      end
      HDR: begin
        if (handshake) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (handshake) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
            seq_d   = seq_q + 16'd1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      hold_q    <= '{default: '0};
      frame_q   <= '{default: '0};
      vmask_q   <= '0;
      seq_q     <= '0;
      timer_q   <= '0;
      idx_q     <= '0;
      overrun_q <= '0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      hold_q    <= hold_d;
      frame_q   <= frame_d;
      vmask_q   <= vmask_d;
      seq_q     <= seq_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign overrun_cnt = overrun_q;
  assign timeout_cnt = tmo_cnt_q;

endmodule

// File: tb/tb_magnitude_aggregator.sv
// Scoreboard bench for magnitude_aggregator: a transaction-level model queues expected
// frame words at each snapshot; an independent monitor pops and compares on every handshake.
module tb_magnitude_aggregator;
  localparam int NUM_CH = 8;
  localparam int DW     = 32;
  localparam int TMO    = 16;
  localparam int NW     = NUM_CH + 1;

  logic                   aclk = 1'b0;
  logic                   areset = 1'b1;
  logic                   enable = 1'b1;
  logic [NUM_CH-1:0]      ch_mask = '0;
  logic [NUM_CH*DW-1:0]   s_tdata = '0;
  logic [NUM_CH-1:0]      s_tvalid = '0;
  logic [DW-1:0]          m_axis_tdata;
  logic                   m_axis_tvalid;
  logic                   m_axis_tready = 1'b1;
  logic                   m_axis_tlast;
  logic                   m_axis_tuser;
  logic [15:0]            overrun_cnt;
  logic [15:0]            timeout_cnt;

  always #5 aclk = ~aclk;

  magnitude_aggregator #(
    .NUM_CH    (NUM_CH),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TMO)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .enable       (enable),
    .ch_mask      (ch_mask),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .overrun_cnt  (overrun_cnt),
    .timeout_cnt  (timeout_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          user;
    logic          last;
  } word_t;

  word_t exp_q[$];
  int    tests = 0;
  int    fails = 0;

  // Reference model: pending set, latest values, age of oldest pending, words left in flight.
  logic [NUM_CH-1:0] m_pend = '0;
  logic [DW-1:0]     m_hold [NUM_CH];
  int                m_timer = 0;
  int                m_left = 0;
  logic [15:0]       m_seq = '0;
  int                m_ovr = 0;
  int                m_tmo = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [NUM_CH-1:0] stb;
    bit idle, complete, tmo_hit, snap;
    if (areset) begin
      m_pend = '0;
      foreach (m_hold[i]) m_hold[i] = '0;
      m_timer = 0;
      m_left = 0;
      m_seq = '0;
      m_ovr = 0;
      m_tmo = 0;
      exp_q.delete();
      return;
    end
    stb      = enable ? s_tvalid : '0;
    idle     = (m_left == 0);
    complete = (ch_mask != '0) && ((m_pend & ch_mask) == ch_mask);
    tmo_hit  = (m_pend != '0) && (m_timer == TMO - 1);
    snap     = idle && (complete || tmo_hit);
    if (snap) begin
      exp_q.push_back('{data: DW'({m_seq, 16'(m_pend)}), user: 1'b1, last: 1'b0});
      for (int i = 0; i < NUM_CH; i++)
        exp_q.push_back('{data: (m_pend[i] ? m_hold[i] : '0), user: 1'b0, last: (i == NUM_CH - 1)});
      if (tmo_hit && !complete && m_tmo < 65535) m_tmo++;
    end
    if (((m_pend & stb) != '0) && !snap && m_ovr < 65535) m_ovr++;
    if (snap || m_pend == '0) m_timer = 0;
    else if (idle) m_timer++;
    if (!idle && m_axis_tready) begin
      m_left--;
      if (m_left == 0) m_seq = m_seq + 16'd1;
    end
    if (snap) m_left = NW;
    for (int i = 0; i < NUM_CH; i++)
      if (stb[i]) m_hold[i] = s_tdata[i*DW +: DW];
    m_pend = snap ? stb : (m_pend | stb);
  endtask

  initial forever begin
    @(posedge aclk);
    model_step();
  end

  // Monitor: compares every handshake against the queue and checks stall stability.
  initial begin
    word_t         w;
    logic          prev_stall;
    logic [DW+1:0] prev_word;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge aclk);
      #2;
      if (areset) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        chk("stall_tvalid_held", 64'(m_axis_tvalid), 64'd1);
        chk("stall_word_stable", 64'({m_axis_tdata, m_axis_tuser, m_axis_tlast}), 64'(prev_word));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", m_axis_tdata);
        end else begin
          w = exp_q.pop_front();
          chk("frame_word", 64'({m_axis_tdata, m_axis_tuser, m_axis_tlast}),
              64'({w.data, w.user, w.last}));
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_word  = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge aclk);
    areset   = 1'b1;
    s_tvalid = '0;
    enable   = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    #2;
  endtask

  task automatic set_data(input logic [DW-1:0] base);
    for (int i = 0; i < NUM_CH; i++) s_tdata[i*DW +: DW] = base + DW'(i);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    s_tvalid      = '0;
    m_axis_tready = 1'b1;
    while ((exp_q.size() != 0 || m_pend != '0 || m_left != 0) && n < 600) begin
      @(negedge aclk);
      #2;
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic latency(output int n);
    n = 0;
    while (n < 200) begin
      @(negedge aclk);
      if (n == 0) s_tvalid = '0;
      #2;
      n++;
      if (m_axis_tvalid) break;
    end
  endtask

  initial begin
    int lat;
    foreach (m_hold[i]) m_hold[i] = '0;

    // Reset state
    do_reset();
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tuser", 64'(m_axis_tuser), 64'd0);
    chk("rst_overrun", 64'(overrun_cnt), 64'd0);
    chk("rst_timeout", 64'(timeout_cnt), 64'd0);

    // Full mask, all channels in one cycle
    @(negedge aclk);
    ch_mask = 8'hFF;
    m_axis_tready = 1'b1;
    set_data(32'h100);
    s_tvalid = 8'hFF;
    latency(lat);
    chk("complete_latency", 64'(lat), 64'd2);
    chk("complete_header", 64'(m_axis_tdata), 64'h0000_00FF);
    chk("complete_tuser", 64'(m_axis_tuser), 64'd1);
    drain("complete_drain");

    // Timeout snapshot with channels 6,7 missing
    do_reset();
    @(negedge aclk);
    ch_mask = 8'hFF;
    set_data(32'h200);
    s_tvalid = 8'h3F;
    latency(lat);
    chk("timeout_latency", 64'(lat), 64'(TMO + 1));
    chk("timeout_header", 64'(m_axis_tdata), 64'h0000_003F);
    drain("timeout_drain");
    chk("timeout_cnt", 64'(timeout_cnt), 64'd1);

    // Overrun on ch3, then strobe during the snapshot cycle
    do_reset();
    @(negedge aclk);
    ch_mask = 8'hFF;
    set_data(32'h300);
    s_tdata[3*DW +: DW] = 32'hA;
    s_tvalid = 8'h08;
    @(negedge aclk);
    s_tdata[3*DW +: DW] = 32'hB;
    @(negedge aclk);
    s_tvalid = 8'hF7;
    @(negedge aclk);
    s_tvalid = '0;
    drain("overrun_drain");
    chk("overrun_cnt", 64'(overrun_cnt), 64'd1);
    @(negedge aclk);
    ch_mask = 8'h01;
    s_tdata[0 +: DW] = 32'hC;
    s_tvalid = 8'h01;
    @(negedge aclk);
    s_tdata[0 +: DW] = 32'hD;
    @(negedge aclk);
    s_tvalid = '0;
    drain("snapcycle_drain");
    chk("snapcycle_overrun", 64'(overrun_cnt), 64'd1);

    // Random traffic with random backpressure
    for (int c = 0; c < 3000; c++) begin
      @(negedge aclk);
      if (c % 200 == 0) ch_mask = ($urandom_range(0, 7) == 0) ? '0 : NUM_CH'($urandom());
      m_axis_tready = 1'($urandom_range(0, 1));
      enable = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < NUM_CH; i++) begin
        s_tvalid[i] = ($urandom_range(0, 9) < 3);
        s_tdata[i*DW +: DW] = $urandom();
      end
    end
    @(negedge aclk);
    enable = 1'b1;
    drain("random_drain");
    chk("random_overrun", 64'(overrun_cnt), 64'(m_ovr));
    chk("random_timeout", 64'(timeout_cnt), 64'(m_tmo));

    // Reset in the middle of a frame
    do_reset();
    @(negedge aclk);
    ch_mask = 8'hFF;
    m_axis_tready = 1'b0;
    set_data(32'h500);
    s_tvalid = 8'h02;
    @(negedge aclk);
    s_tvalid = 8'hFF;
    latency(lat);
    chk("midrst_overrun_before", 64'(overrun_cnt), 64'd1);
    @(negedge aclk);
    m_axis_tready = 1'b1;
    repeat (2) @(negedge aclk);
    @(negedge aclk);
    m_axis_tready = 1'b0;
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    m_axis_tready = 1'b1;
    #2;
    chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("midrst_overrun", 64'(overrun_cnt), 64'd0);
    chk("midrst_timeout", 64'(timeout_cnt), 64'd0);
    @(negedge aclk);
    set_data(32'h600);
    s_tvalid = 8'hFF;
    latency(lat);
    chk("midrst_seq0_header", 64'(m_axis_tdata), 64'h0000_00FF);
    drain("midrst_drain");

    // Sequence wrap via backdoor
    @(negedge aclk);
    force dut.seq_q = 16'hFFFF;
    m_seq = 16'hFFFF;
    @(posedge aclk);
    #1;
    release dut.seq_q;
    @(negedge aclk);
    ch_mask = 8'hFF;
    set_data(32'h700);
    s_tvalid = 8'hFF;
    latency(lat);
    chk("wrap_header_ffff", 64'(m_axis_tdata[31:16]), 64'hFFFF);
    drain("wrap_drain1");
    @(negedge aclk);
    set_data(32'h800);
    s_tvalid = 8'hFF;
    latency(lat);
    chk("wrap_header_0000", 64'(m_axis_tdata[31:16]), 64'h0000);
    drain("wrap_drain2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
